// File: rtl/fir_sample_feeder_if.sv
// Producer-side handshake and filter-side strobe bundle for fir_sample_feeder.
// master = producer/filter environment, slave = the feeder itself.
interface fir_sample_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [DATA_WIDTH-1:0] output_data;
  logic                  output_data_flag;
  logic [LW-1:0]         level;

  modport master (
    output in_data, in_valid, flush,
    input  in_ready, output_data, output_data_flag, level
  );

  modport slave (
    input  in_data, in_valid, flush,
    output in_ready, output_data, output_data_flag, level
  );
endinterface

// File: rtl/fir_sample_feeder.sv
// Buffers producer samples and emits them as 1-cycle strobes at least GAP cycles apart;
// 1 cycle from push to strobe when idle; in_ready drops only when the FIFO holds DEPTH samples.
module fir_sample_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int GAP        = 10
) (
  input logic                clk,
  input logic                rst_n,
  fir_sample_feeder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LW-1:0] FULL   = LW'(DEPTH);
  localparam logic [CW-1:0] RELOAD = CW'(GAP - 1);

  typedef enum logic {IDLE, SPACING} pace_t;

  pace_t                 state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  flag_q;
  logic                  in_ready;
  logic                  push;
  logic                  issue;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign in_ready = (level_q != FULL);
  assign push     = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (level_q != '0) begin
            issue = 1'b1;
            if (GAP > 1) begin
              state_d = SPACING;
              cnt_d   = RELOAD;
            end
          end
        end
        SPACING: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
        flag_q  <= 1'b0;
      end else begin
        flag_q <= issue;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (issue) begin
          rd_ptr <= rd_ptr + PW'(1);
          data_q <= mem[rd_ptr];
        end
        case ({push, issue})
          2'b10:   level_q <= level_q + LW'(1);
          2'b01:   level_q <= level_q - LW'(1);
          default: level_q <= level_q;
        endcase
      end
    end
  end

  // Storage needs no reset: level and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  assign bus.in_ready         = in_ready;
  assign bus.output_data      = data_q;
  assign bus.output_data_flag = flag_q;
  assign bus.level            = level_q;
endmodule
